// File: rtl/pw_pkg.sv
// Shared definitions for the pointwise MAC lane: default widths, sequencer states
// and the saturation bounds of the default-width accumulator.
package pw_pkg;
    localparam int ACT_BITWIDTH_DEF  = 16;
    localparam int WGT_BITWIDTH_DEF  = 16;
    localparam int SUM_BITWIDTH_DEF  = 64;
    localparam int ADDR_BITWIDTH_DEF = 12;
    localparam int CH_BITWIDTH_DEF   = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [SUM_BITWIDTH_DEF-1:0] SUM_MAX = {1'b0, {(SUM_BITWIDTH_DEF-1){1'b1}}};
    localparam logic [SUM_BITWIDTH_DEF-1:0] SUM_MIN = {1'b1, {(SUM_BITWIDTH_DEF-1){1'b0}}};
endpackage

// File: rtl/macc.sv
// Combinational signed multiply-accumulate: sum_o = a_i * b_i + c_i, computed at
// INTER_BITWIDTH so the caller can detect overflow of the SUM_IN_BITWIDTH range.
module macc #(
    parameter int ACT_BITWIDTH    = 16,
    parameter int WGT_BITWIDTH    = 16,
    parameter int SUM_IN_BITWIDTH = 64,
    parameter int INTER_BITWIDTH  = 65
) (
    input  logic signed [ACT_BITWIDTH-1:0]    a_i,
    input  logic signed [WGT_BITWIDTH-1:0]    b_i,
    input  logic signed [SUM_IN_BITWIDTH-1:0] c_i,
    output logic signed [INTER_BITWIDTH-1:0]  sum_o
);
    logic signed [ACT_BITWIDTH+WGT_BITWIDTH-1:0] prod;

    assign prod  = a_i * b_i;
    assign sum_o = INTER_BITWIDTH'(prod) + INTER_BITWIDTH'(c_i);
endmodule

// File: rtl/pw_macc_seq.sv
// Sequencer for one pointwise MAC lane: streams N operand pairs from the buffers,
// accumulates them onto a bias with saturation and offers the result valid/ready.
module pw_macc_seq
    import pw_pkg::*;
#(
    parameter int ACT_BITWIDTH  = ACT_BITWIDTH_DEF,
    parameter int WGT_BITWIDTH  = WGT_BITWIDTH_DEF,
    parameter int SUM_BITWIDTH  = SUM_BITWIDTH_DEF,
    parameter int ADDR_BITWIDTH = ADDR_BITWIDTH_DEF,
    parameter int CH_BITWIDTH   = CH_BITWIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CH_BITWIDTH-1:0]   cfg_num_ch,
    input  logic [ADDR_BITWIDTH-1:0] cfg_act_base,
    input  logic [ADDR_BITWIDTH-1:0] cfg_wgt_base,
    input  logic [SUM_BITWIDTH-1:0]  cfg_bias,
    output logic                     busy,
    output logic                     rd_en,
    output logic [ADDR_BITWIDTH-1:0] act_addr,
    output logic [ADDR_BITWIDTH-1:0] wgt_addr,
    input  logic [ACT_BITWIDTH-1:0]  act_data,
    input  logic [WGT_BITWIDTH-1:0]  wgt_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_BITWIDTH-1:0]  out_data,
    output logic                     out_sat
);
    localparam logic [SUM_BITWIDTH-1:0] ACC_MAX = {1'b0, {(SUM_BITWIDTH-1){1'b1}}};
    localparam logic [SUM_BITWIDTH-1:0] ACC_MIN = {1'b1, {(SUM_BITWIDTH-1){1'b0}}};

    state_t                   state_q, state_d;
    logic [CH_BITWIDTH-1:0]   num_ch_q, num_ch_d;
    logic [CH_BITWIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_BITWIDTH-1:0] act_addr_q, act_addr_d;
    logic [ADDR_BITWIDTH-1:0] wgt_addr_q, wgt_addr_d;
    logic [SUM_BITWIDTH-1:0]  acc_q, acc_d;
    logic                     sat_q, sat_d;
    logic                     rd_q;

    logic signed [SUM_BITWIDTH:0] mac_sum;
    logic                         mac_ovf;
    logic [SUM_BITWIDTH-1:0]      mac_clamped;

    macc #(
        .ACT_BITWIDTH   (ACT_BITWIDTH),
        .WGT_BITWIDTH   (WGT_BITWIDTH),
        .SUM_IN_BITWIDTH(SUM_BITWIDTH),
        .INTER_BITWIDTH (SUM_BITWIDTH + 1)
    ) u_macc (
        .a_i  ($signed(act_data)),
        .b_i  ($signed(wgt_data)),
        .c_i  ($signed(acc_q)),
        .sum_o(mac_sum)
    );

    // The two top bits of the widened sum disagree exactly when it left the SUM range.
    assign mac_ovf     = mac_sum[SUM_BITWIDTH] ^ mac_sum[SUM_BITWIDTH-1];
    assign mac_clamped = mac_ovf ? (mac_sum[SUM_BITWIDTH] ? ACC_MIN : ACC_MAX)
                                 : mac_sum[SUM_BITWIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        num_ch_d   = num_ch_q;
        cnt_d      = cnt_q;
        act_addr_d = act_addr_q;
        wgt_addr_d = wgt_addr_q;
        acc_d      = acc_q;
        sat_d      = sat_q;

        if (rd_q) begin
            acc_d = mac_clamped;
            if (mac_ovf) begin
                sat_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_ch_d   = cfg_num_ch;
                    cnt_d      = '0;
                    act_addr_d = cfg_act_base;
                    wgt_addr_d = cfg_wgt_base;
                    acc_d      = cfg_bias;
                    sat_d      = 1'b0;
                    state_d    = (cfg_num_ch != '0) ? FETCH : OUT;
                end
            end
            FETCH: begin
                if (cnt_q == num_ch_q - CH_BITWIDTH'(1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt_q + CH_BITWIDTH'(1);
                    act_addr_d = act_addr_q + ADDR_BITWIDTH'(1);
                    wgt_addr_d = wgt_addr_q + ADDR_BITWIDTH'(1);
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            num_ch_q   <= '0;
            cnt_q      <= '0;
            act_addr_q <= '0;
            wgt_addr_q <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_ch_q   <= num_ch_d;
            cnt_q      <= cnt_d;
            act_addr_q <= act_addr_d;
            wgt_addr_q <= wgt_addr_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            rd_q       <= (state_q == FETCH);
        end
    end

    assign busy      = (state_q != IDLE);
    assign rd_en     = (state_q == FETCH);
    assign out_valid = (state_q == OUT);
    assign act_addr  = act_addr_q;
    assign wgt_addr  = wgt_addr_q;
    assign out_data  = acc_q;
    assign out_sat   = sat_q;
endmodule
